systolic_mm_ctrl: RTL and testbench



---
 rtl/sysmm_pkg.sv | 25 ++
 rtl/sysmm_skew_mux.sv | 30 +++
 rtl/systolic_mm_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_systolic_mm_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysmm_pkg.sv
// Shared types and index helpers for the systolic multiply sequencer.
package sysmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Wavefronts needed to push every operand pair through an n x n array.
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int elem_lo(input int i, input int j, input int n, input int w);
        return (i * n + j) * w;
    endfunction

    function automatic int lane_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/sysmm_skew_mux.sv
// Combinational wavefront selector: row lane i carries A[i][k-i], column lane j carries B[k-j][j].
module sysmm_skew_mux
    import sysmm_pkg::*;
#(
    parameter int N        = 4,
    parameter int BITWIDTH = 8,
    parameter int KW       = 4
) (
    input  logic [N*N*BITWIDTH-1:0] i_a_mat,
    input  logic [N*N*BITWIDTH-1:0] i_b_mat,
    input  logic [KW-1:0]           i_k,
    output logic [N*BITWIDTH-1:0]   o_a_lane,
    output logic [N*BITWIDTH-1:0]   o_b_lane
);

    always_comb begin
        o_a_lane = '0;
        o_b_lane = '0;
        for (int i = 0; i < N; i++) begin
            // Lanes outside their skew window stay zero so they add nothing to the accumulators.
            if ((int'(i_k) >= i) && (int'(i_k) - i < N)) begin
                o_a_lane[lane_lo(i, BITWIDTH) +: BITWIDTH] =
                    i_a_mat[elem_lo(i, int'(i_k) - i, N, BITWIDTH) +: BITWIDTH];
                o_b_lane[lane_lo(i, BITWIDTH) +: BITWIDTH] =
                    i_b_mat[elem_lo(int'(i_k) - i, i, N, BITWIDTH) +: BITWIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Job sequencer for the output-stationary systolic array: result valid 3N+DRAIN_CYC cycles after accept,
// held in DONE until out_ready; one job at a time. SYSMM_PERF_CNT_EN adds perf_jobs/perf_busy counters.
module systolic_mm_ctrl
    import sysmm_pkg::*;
#(
    parameter int N         = 4,
    parameter int BITWIDTH  = 8,
    parameter int DRAIN_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*N*BITWIDTH-1:0]   in_a,
    input  logic [N*N*BITWIDTH-1:0]   in_b,
    output logic                      arr_clr,
    output logic                      arr_en,
    output logic [N*BITWIDTH-1:0]     arr_a,
    output logic [N*BITWIDTH-1:0]     arr_b,
    input  logic [N*N*2*BITWIDTH-1:0] arr_res,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*N*2*BITWIDTH-1:0] out_c,
    output logic                      busy
`ifdef SYSMM_PERF_CNT_EN
    ,
    output logic [31:0]               perf_jobs,
    output logic [31:0]               perf_busy
`else
`endif
);

    localparam int            KW     = $clog2(3 * N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(feed_len(N) - 1);
    localparam int            DW     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);

    state_t                      r_state;
    logic [KW-1:0]               r_k;
    logic [DW-1:0]               r_drain;
    logic [N*N*BITWIDTH-1:0]     r_a_buf;
    logic [N*N*BITWIDTH-1:0]     r_b_buf;
    logic                        r_in_ready;
    logic                        r_arr_clr;
    logic                        r_arr_en;
    logic [N*BITWIDTH-1:0]       r_arr_a;
    logic [N*BITWIDTH-1:0]       r_arr_b;
    logic                        r_out_valid;
    logic [N*N*2*BITWIDTH-1:0]   r_out_c;
    logic                        r_busy;

    logic [KW-1:0]               w_mux_k;
    logic [N*BITWIDTH-1:0]       w_a_lane;
    logic [N*BITWIDTH-1:0]       w_b_lane;

    // Lanes are registered, so the mux looks one step ahead of the step currently on the outputs.
    assign w_mux_k = (r_state == FEED) ? (r_k + KW'(1)) : '0;

    sysmm_skew_mux #(
        .N        (N),
        .BITWIDTH (BITWIDTH),
        .KW       (KW)
    ) u_skew_mux (
        .i_a_mat  (r_a_buf),
        .i_b_mat  (r_b_buf),
        .i_k      (w_mux_k),
        .o_a_lane (w_a_lane),
        .o_b_lane (w_b_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_drain     <= '0;
            r_a_buf     <= '0;
            r_b_buf     <= '0;
            r_in_ready  <= 1'b1;
            r_arr_clr   <= 1'b0;
            r_arr_en    <= 1'b0;
            r_arr_a     <= '0;
            r_arr_b     <= '0;
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_buf    <= in_a;
                        r_b_buf    <= in_b;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_arr_clr  <= 1'b1;
                        r_state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_arr_clr <= 1'b0;
                    r_arr_en  <= 1'b1;
                    r_arr_a   <= w_a_lane;
                    r_arr_b   <= w_b_lane;
                    r_k       <= '0;
                    r_state   <= FEED;
                end
                FEED: begin
                    if (r_k == K_LAST) begin
                        r_arr_a <= '0;
                        r_arr_b <= '0;
                        r_drain <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_arr_a <= w_a_lane;
                        r_arr_b <= w_b_lane;
                        r_k     <= r_k + KW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain == D_LAST) begin
                        r_out_c     <= arr_res;
                        r_out_valid <= 1'b1;
                        r_arr_en    <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign arr_clr   = r_arr_clr;
    assign arr_en    = r_arr_en;
    assign arr_a     = r_arr_a;
    assign arr_b     = r_arr_b;
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign busy      = r_busy;

`ifdef SYSMM_PERF_CNT_EN
    logic [31:0] r_perf_jobs;
    logic [31:0] r_perf_busy;
    logic        w_busy_inc;

    // The accepting IDLE cycle is charged to the job; a DONE cycle waiting on the consumer is not.
    assign w_busy_inc = (r_state == IDLE) ? (in_valid && r_in_ready)
                                          : !((r_state == DONE) && !out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_jobs <= '0;
            r_perf_busy <= '0;
        end else begin
            if ((r_state == DONE) && out_ready) begin
                r_perf_jobs <= r_perf_jobs + 32'd1;
            end
            if (w_busy_inc) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
        end
    end

    assign perf_jobs = r_perf_jobs;
    assign perf_busy = r_perf_busy;
`else
`endif

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl with a behavioural output-stationary array driving arr_res.
module tb_systolic_mm_ctrl;

    localparam int N   = 4;
    localparam int BW  = 8;
    localparam int D   = 1;
    localparam int LAT = 3 * N + D;

    typedef logic [N*N*BW-1:0]   mat_t;
    typedef logic [N*N*2*BW-1:0] res_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    mat_t              in_a;
    mat_t              in_b;
    logic              arr_clr;
    logic              arr_en;
    logic [N*BW-1:0]   arr_a;
    logic [N*BW-1:0]   arr_b;
    res_t              arr_res;
    logic              out_valid;
    logic              out_ready;
    res_t              out_c;
    logic              busy;
`ifdef SYSMM_PERF_CNT_EN
    logic [31:0]       perf_jobs;
    logic [31:0]       perf_busy;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    res_t exp_q[$];
    int   hs_q[$];

    always #5 clk = ~clk;

    systolic_mm_ctrl #(.N(N), .BITWIDTH(BW), .DRAIN_CYC(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .arr_clr   (arr_clr),
        .arr_en    (arr_en),
        .arr_a     (arr_a),
        .arr_b     (arr_b),
        .arr_res   (arr_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
`ifdef SYSMM_PERF_CNT_EN
        ,
        .perf_jobs (perf_jobs),
        .perf_busy (perf_busy)
`endif
    );

    // Behavioural array: A flows right, B flows down, each PE accumulates its inputs' product.
    logic [2*BW-1:0] acc [N][N];
    logic [BW-1:0]   pa  [N][N];
    logic [BW-1:0]   pb  [N][N];

    function automatic logic [BW-1:0] a_in(input int i, input int j);
        return (j == 0) ? arr_a[i*BW +: BW] : pa[i][(j == 0) ? 0 : j-1];
    endfunction

    function automatic logic [BW-1:0] b_in(input int i, input int j);
        return (i == 0) ? arr_b[j*BW +: BW] : pb[(i == 0) ? 0 : i-1][j];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clr) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else if (arr_en) begin
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                    acc[i][j] <= acc[i][j] + (16'(a_in(i, j)) * 16'(b_in(i, j)));
                end
            end
        end
    end

    always_comb begin
        arr_res = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_res[(i*N+j)*2*BW +: 2*BW] = acc[i][j];
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // kind 0: fill v, 1: identity, 2: i*N+j+1, 3: 16*i+j
    function automatic mat_t mk(input int kind, input int v);
        mat_t m;
        m = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int e;
                case (kind)
                    0:       e = v;
                    1:       e = (i == j) ? 1 : 0;
                    2:       e = i * N + j + 1;
                    default: e = 16 * i + j;
                endcase
                m[(i*N+j)*BW +: BW] = BW'(e);
            end
        return m;
    endfunction

    // Hand-derived result patterns; kind 4 is all-ones times (i*N+j+1): column sums 4j+28.
    function automatic res_t rk(input int kind, input int v);
        res_t r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int e;
                case (kind)
                    0:       e = v;
                    1:       e = (i == j) ? 1 : 0;
                    2:       e = i * N + j + 1;
                    3:       e = 16 * i + j;
                    default: e = 4 * j + 28;
                endcase
                r[(i*N+j)*2*BW +: 2*BW] = 16'(e);
            end
        return r;
    endfunction

    // Handshakes are recorded on the edge itself, before the DUT registers move.
    always @(posedge clk) begin
        if (in_valid && in_ready && !reset)
            hs_q.push_back(cyc);
    end

    logic prev_ov  = 1'b0;
    logic prev_en  = 1'b0;
    logic prev_clr = 1'b0;
    int   clr_len  = 0;

    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0 || hs_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                chk("result", out_c, exp_q.pop_front());
                chk("latency", 256'(cyc - hs_q.pop_front()), 256'(LAT));
            end
        end
        if (arr_en && !prev_en)
            chk("clr_then_en", {prev_clr, clr_len == 1}, 2'b11);
        clr_len  <= arr_clr ? (prev_clr ? clr_len + 1 : 1) : clr_len;
        prev_ov  <= out_valid;
        prev_en  <= arr_en;
        prev_clr <= arr_clr;
    end

    task automatic send(input mat_t a, input mat_t b, input res_t e, input bit push);
        int n = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(out_valid && out_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid && out_ready)) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int n;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {in_ready, arr_clr, arr_en, out_valid, busy}, 5'b10000);
        chk("reset_lanes", {arr_a, arr_b}, 0);
        chk("reset_outc", out_c, 0);
        reset = 1'b0;

        // identity x (i*N+j+1)
        send(mk(1, 0), mk(2, 0), rk(2, 0), 1'b1);
        wait_done();

        // all 2 x all 3
        send(mk(0, 2), mk(0, 3), rk(0, 24), 1'b1);
        wait_done();

        // lane windows with A(i,j)=16i+j, B=identity
        send(mk(3, 0), mk(1, 0), rk(3, 0), 1'b1);
        for (int s = 0; s < 3*N-2; s++) begin
            @(negedge clk);
            if (s == 0) chk("lanes_k0", {arr_a, arr_b}, {32'h0000_0000, 32'h0000_0001});
            if (s == 1) chk("lanes_k1", {arr_a, arr_b}, {32'h0000_1001, 32'h0000_0000});
            if (s == 3) chk("lanes_k3", {arr_a, arr_b}, {32'h3021_1203, 32'h0000_0000});
            if (s == 6) chk("lanes_k6", {arr_a, arr_b}, {32'h3300_0000, 32'h0100_0000});
        end
        wait_done();

        // consumer back-pressure with a stray job offered meanwhile
        out_ready = 1'b0;
        send(mk(0, 1), mk(2, 0), rk(4, 0), 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("stall_timeout", 0, 1);
        viol = 0;
        for (int s = 0; s < 20; s++) begin
            in_valid = 1'b1; in_a = mk(0, 7); in_b = mk(0, 9);
            @(negedge clk);
            if (out_c !== rk(4, 0) || in_ready || !out_valid || arr_en || !busy) viol++;
        end
        chk("stall_stable", viol, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_idle", {in_ready, out_valid, busy}, 3'b100);
        send(mk(1, 0), mk(1, 0), rk(1, 0), 1'b1);
        wait_done();

        // abort mid-FEED, then a clean job
        send(mk(0, 3), mk(0, 5), '0, 1'b0);
        repeat (6) @(negedge clk);
        chk("abort_at_k5", {arr_en, arr_a}, {1'b1, 32'h0303_0000});
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ctl", {in_ready, arr_clr, arr_en, out_valid, busy}, 5'b10000);
        chk("abort_lanes", {arr_a, arr_b}, 0);
        chk("abort_outc", out_c, 0);
        reset = 1'b0;
        hs_q.delete();
        send(mk(0, 1), mk(0, 1), rk(0, 4), 1'b1);
        wait_done();

`ifdef SYSMM_PERF_CNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hs_q.delete();
        repeat (3) begin
            send(mk(0, 1), mk(0, 1), rk(0, 4), 1'b1);
            wait_done();
        end
        chk("perf_jobs", perf_jobs, 3);
        chk("perf_busy", perf_busy, 3 * (LAT + 1));
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
